multicycle_sequencer: RTL and testbench
=======================================

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 SHALL provide parameter NUM_CLASSES, default 8: number of one-hot instruction classes.
REQ-002 SHALL provide parameter MAX_PHASES, default 8: number of one-hot phase states; PW = clog2(MAX_PHASES).
REQ-003 SHALL provide parameter LEN_TABLE, NUM_CLASSES*4 bits, default lengths 4,5,3,4,4,4,4,4 for classes 0..7: total phases per class, legal range 2..MAX_PHASES.
REQ-004 SHALL provide parameter SHORT_MASK, NUM_CLASSES bits, default 8'b0000_0100: classes whose length drops by one when short_take=1.
REQ-005 SHALL provide parameter STALL_MASK, NUM_CLASSES bits, default 8'b0000_0010: classes that hold their last phase while busy=1.
REQ-006 SHALL provide parameter CNT_W, default 32: width of the performance counters.
REQ-007 clk  in  1  single clock; all state updates on the rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-low.
REQ-009 run  in  1  permits a new fetch from phase 0.
REQ-010 class_onehot  in  NUM_CLASSES  decoded instruction class, sampled in phase 1.
REQ-011 short_take  in  1  condition result for SHORT_MASK classes, sampled in phase 1.
REQ-012 busy  in  1  long-latency unit (mul/div) still computing.
REQ-013 exc_req  in  1  exception/abort request.
REQ-014 phase  out  MAX_PHASES  one-hot current phase.
REQ-015 phase_idx  out  PW  binary index of current phase.
REQ-016 fetch_en  out  1  PC/IR load strobe (phase 0 and run=1).
REQ-017 last_phase, retire, stall, exc_ack, illegal  out  1 each  status pulses/levels per Function.
REQ-018 retired_cnt, stall_cnt  out  CNT_W each  performance counters.

Function
REQ-019 Phase 0: fetch_en = run; advance to phase 1 if run=1, else hold phase 0.
REQ-020 Phase 1: latch class_onehot and effective length L = LEN_TABLE[class], minus 1 if SHORT_MASK[class] and short_take=1, floored at 2.
REQ-021 class_onehot not exactly one-hot in phase 1 SHALL pulse illegal for one cycle and use L = 2.
REQ-022 Phase k, 1 <= k < L-1: advance to phase k+1 unconditionally.
REQ-023 Phase L-1 is the last phase: last_phase = 1 combinationally.
REQ-024 In the last phase, STALL_MASK[class] and busy=1 SHALL hold the phase, drive stall=1, increment stall_cnt per held cycle.
REQ-025 Otherwise the last phase SHALL pulse retire for one cycle, increment retired_cnt, return to phase 0 next cycle.
REQ-026 exc_req=1 in any phase >= 1 SHALL force phase 0 next cycle, pulse exc_ack, suppress retire and retired_cnt increment.
REQ-027 exc_req in phase 0 SHALL be ignored; exc_req wins over a simultaneous last-phase retire or stall.
REQ-028 Counters SHALL wrap modulo 2^CNT_W without flag.
REQ-029 phase SHALL be exactly one-hot in every cycle after reset; phase_idx SHALL always match it.
REQ-030 Latched class/length SHALL not change outside phase 1.

Reset
REQ-031 rst=0 SHALL asynchronously force phase = 1 (phase 0), phase_idx = 0, both counters = 0, latched class = 0, latched L = 2.
REQ-032 During reset all 1-bit outputs SHALL be 0, including fetch_en.
REQ-033 Reset mid-instruction SHALL abandon it with no retire or exc_ack; first fetch_en is in the first cycle after release with run=1.

Verification
REQ-034 Class 0 (L=4), run=1, busy=0 -> phases 0,1,2,3,0; retire in phase 3; retired_cnt=1; fetch_en twice in 5 cycles.
REQ-035 Class 2 with short_take=1 -> L=2, phases 0,1,0, retire in phase 1; short_take=0 -> L=3.
REQ-036 Class 1 (L=5), busy=1 for 6 cycles entering phase 4 -> phase 4 held 6 cycles, stall_cnt=6, retire on 7th.
REQ-037 Class 0, exc_req=1 in phase 2 -> exc_ack pulse, phase 0 next cycle, retired_cnt unchanged; exc_req with last phase -> no retire.
REQ-038 class_onehot=8'b0000_0011 in phase 1 -> illegal pulse, retire in phase 1; rst=0 asserted in phase 3 -> outputs zeroed immediately, phase 0 held until release.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multi-cycle instruction phase sequencer: one-hot phase walk whose length is
// chosen per instruction class, with last-phase stall, early-exit and abort.
module multicycle_sequencer #(
  parameter int                         NUM_CLASSES = 8,
  parameter int                         MAX_PHASES  = 8,
  parameter logic [NUM_CLASSES*4-1:0]   LEN_TABLE   = 32'h4444_4354,
  parameter logic [NUM_CLASSES-1:0]     SHORT_MASK  = 8'b0000_0100,
  parameter logic [NUM_CLASSES-1:0]     STALL_MASK  = 8'b0000_0010,
  parameter int                         CNT_W       = 32,
  localparam int                        PW          = $clog2(MAX_PHASES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic [NUM_CLASSES-1:0] class_onehot,
  input  logic                   short_take,
  input  logic                   busy,
  input  logic                   exc_req,
  output logic [MAX_PHASES-1:0]  phase,
  output logic [PW-1:0]          phase_idx,
  output logic                   fetch_en,
  output logic                   last_phase,
  output logic                   retire,
  output logic                   stall,
  output logic                   exc_ack,
  output logic                   illegal,
  output logic [CNT_W-1:0]       retired_cnt,
  output logic [CNT_W-1:0]       stall_cnt
);
  // state | meaning
  // 0     | fetch: wait for run, strobe fetch_en
  // 1     | decode: latch class and effective length
  // 2..L-2| execute: advance unconditionally
  // L-1   | last: retire, or hold while a stall-class unit is busy
  localparam int IW = (PW > 4) ? PW : 4;

  logic [PW-1:0]          idx_q, idx_d;
  logic [NUM_CLASSES-1:0] class_q, class_cur, class_eff;
  logic [3:0]             len_q, len_cur, len_eff, len_raw, last_idx;
  logic                   legal, short_en, is_p0, is_p1, is_last, hold_stall;

  // Class decode is combinational so a two-phase instruction can finish in phase 1.
  always_comb begin
    legal    = (class_onehot != '0) &&
               ((class_onehot & (class_onehot - NUM_CLASSES'(1))) == '0);
    len_raw  = 4'd2;
    short_en = 1'b0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (class_onehot[i]) begin
        len_raw  = LEN_TABLE[4*i +: 4];
        short_en = SHORT_MASK[i];
      end
    end
    class_cur = legal ? class_onehot : '0;
    len_cur   = 4'd2;
    if (legal) begin
      len_cur = (short_en && short_take) ? (len_raw - 4'd1) : len_raw;
      if (len_cur < 4'd2) len_cur = 4'd2;
    end
  end

  always_comb begin
    is_p0      = (idx_q == '0);
    is_p1      = (idx_q == PW'(1));
    class_eff  = is_p1 ? class_cur : class_q;
    len_eff    = is_p1 ? len_cur : len_q;
    last_idx   = len_eff - 4'd1;
    is_last    = !is_p0 && (IW'(idx_q) == IW'(last_idx));
    hold_stall = (|(class_eff & STALL_MASK)) && busy;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q       <= '0;
      class_q     <= '0;
      len_q       <= 4'd2;
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      idx_q <= idx_d;
      if (is_p1) begin
        class_q <= class_cur;
        len_q   <= len_cur;
      end
      if (retire) retired_cnt <= retired_cnt + CNT_W'(1);
      if (stall)  stall_cnt   <= stall_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    idx_d = idx_q;
    if (is_p0) begin
      if (run) idx_d = PW'(1);
    end else if (exc_req) begin
      idx_d = '0;
    end else if (is_last) begin
      if (!hold_stall) idx_d = '0;
    end else begin
      idx_d = idx_q + PW'(1);
    end
  end

  // Pulses are gated by the async reset so they drop the instant it asserts.
  always_comb begin
    phase        = '0;
    phase[idx_q] = 1'b1;
    phase_idx    = idx_q;
    fetch_en     = rst && is_p0 && run;
    last_phase   = rst && is_last;
    exc_ack      = rst && !is_p0 && exc_req;
    retire       = rst && is_last && !exc_req && !hold_stall;
    stall        = rst && is_last && !exc_req && hold_stall;
    illegal      = rst && is_p1 && !legal;
  end
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: a per-cycle vector table walking
// several instructions, plus hand sequences for reset behaviour.
module tb_multicycle_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic       run, short_take, busy, exc_req;
  logic [7:0] class_onehot;
  logic [7:0] phase;
  logic [2:0] phase_idx;
  logic       fetch_en, last_phase, retire, stall, exc_ack, illegal;
  logic [31:0] retired_cnt, stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .class_onehot(class_onehot),
    .short_take(short_take), .busy(busy), .exc_req(exc_req),
    .phase(phase), .phase_idx(phase_idx), .fetch_en(fetch_en),
    .last_phase(last_phase), .retire(retire), .stall(stall),
    .exc_ack(exc_ack), .illegal(illegal),
    .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic       run;
    logic [7:0] cls;
    logic       st;
    logic       bsy;
    logic       exc;
    logic [2:0] idx;
    logic       fe, lp, rt, sl, ea, il;
  } vec_t;

  vec_t vec[64];
  int   nvec = 0;

  task automatic add(input logic r, input logic [7:0] c, input logic s,
                     input logic b, input logic e, input logic [2:0] i,
                     input logic fe, input logic lp, input logic rt,
                     input logic sl, input logic ea, input logic il);
    vec[nvec] = '{r, c, s, b, e, i, fe, lp, rt, sl, ea, il};
    nvec++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [7:0] c, input logic s,
                       input logic b, input logic e);
    run = r; class_onehot = c; short_take = s; busy = b; exc_req = e;
  endtask

  initial begin
    logic [31:0] exp_ret, exp_stl;
    logic [7:0]  one;
    //  run  cls         st  bsy exc  idx fe lp rt sl ea il
    // class 0, L=4
    add(1, 8'h00, 0, 0, 0, 3'd0, 1, 0, 0, 0, 0, 0);
    add(0, 8'h01, 0, 0, 0, 3'd1, 0, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 3'd2, 0, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 3'd3, 0, 1, 1, 0, 0, 0);
    add(1, 8'h00, 0, 0, 0, 3'd0, 1, 0, 0, 0, 0, 0);
    // class 2 short_take=1 -> L=2, then run low, then short_take=0 -> L=3
    add(0, 8'h04, 1, 0, 0, 3'd1, 0, 1, 1, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
    add(1, 8'h00, 0, 0, 0, 3'd0, 1, 0, 0, 0, 0, 0);
    add(0, 8'h04, 0, 0, 0, 3'd1, 0, 0, 0, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 3'd2, 0, 1, 1, 0, 0, 0);
    add(1, 8'h00, 0, 0, 0, 3'd0, 1, 0, 0, 0, 0, 0);
    // class 1, L=5, busy for 6 cycles in phase 4
    add(0, 8'h02, 0, 0, 0, 3'd1, 0, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 1, 0, 3'd2, 0, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 1, 0, 3'd3, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++)
      add(0, 8'h00, 0, 1, 0, 3'd4, 0, 1, 0, 1, 0, 0);
    add(0, 8'h00, 0, 0, 0, 3'd4, 0, 1, 1, 0, 0, 0);
    // class 0 with exception in phase 2, ignored exc in phase 0
    add(1, 8'h00, 0, 0, 0, 3'd0, 1, 0, 0, 0, 0, 0);
    add(0, 8'h01, 0, 0, 0, 3'd1, 0, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 1, 3'd2, 0, 0, 0, 0, 1, 0);
    add(0, 8'h00, 0, 0, 1, 3'd0, 0, 0, 0, 0, 0, 0);
    add(1, 8'h00, 0, 0, 0, 3'd0, 1, 0, 0, 0, 0, 0);
    add(0, 8'h01, 0, 0, 0, 3'd1, 0, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 3'd2, 0, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 1, 3'd3, 0, 1, 0, 0, 1, 0);
    // illegal class -> L=2
    add(1, 8'h00, 0, 0, 0, 3'd0, 1, 0, 0, 0, 0, 0);
    add(0, 8'h03, 0, 1, 0, 3'd1, 0, 1, 1, 0, 0, 1);
    add(0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
    // exception beats an active stall
    add(1, 8'h00, 0, 0, 0, 3'd0, 1, 0, 0, 0, 0, 0);
    add(0, 8'h02, 0, 0, 0, 3'd1, 0, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 3'd2, 0, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 3'd3, 0, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 1, 0, 3'd4, 0, 1, 0, 1, 0, 0);
    add(0, 8'h00, 0, 1, 1, 3'd4, 0, 1, 0, 0, 1, 0);
    add(0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0);

    // reset: outputs must be zero even with run=1
    rst = 1'b0;
    drive(1, 8'h01, 0, 0, 1);
    repeat (2) @(negedge clk);
    #1;
    check("rst_phase", 32'(phase), 32'h1);
    check("rst_idx", 32'(phase_idx), 0);
    check("rst_pulses", {fetch_en, last_phase, retire, stall, exc_ack, illegal}, 0);
    check("rst_cnt", retired_cnt | stall_cnt, 0);
    @(negedge clk);
    rst = 1'b1;

    exp_ret = 0;
    exp_stl = 0;
    for (int v = 0; v < nvec; v++) begin
      drive(vec[v].run, vec[v].cls, vec[v].st, vec[v].bsy, vec[v].exc);
      #1;
      one = 8'h01 << vec[v].idx;
      check($sformatf("v%0d_idx", v), 32'(phase_idx), 32'(vec[v].idx));
      check($sformatf("v%0d_phase", v), 32'(phase), 32'(one));
      check($sformatf("v%0d_outs", v),
            {fetch_en, last_phase, retire, stall, exc_ack, illegal},
            {vec[v].fe, vec[v].lp, vec[v].rt, vec[v].sl, vec[v].ea, vec[v].il});
      check($sformatf("v%0d_retired_cnt", v), retired_cnt, exp_ret);
      check($sformatf("v%0d_stall_cnt", v), stall_cnt, exp_stl);
      if (vec[v].rt) exp_ret++;
      if (vec[v].sl) exp_stl++;
      @(negedge clk);
    end
    #1;
    check("final_retired_cnt", retired_cnt, 5);
    check("final_stall_cnt", stall_cnt, 7);

    // reset asserted in phase 3 of a class 0 instruction
    drive(1, 8'h00, 0, 0, 0);
    @(negedge clk);
    drive(0, 8'h01, 0, 0, 0);
    @(negedge clk);
    drive(1, 8'h00, 0, 0, 0);
    @(negedge clk);
    #1;
    check("pre_rst_idx", 32'(phase_idx), 3);
    check("pre_rst_retire", 32'(retire), 1);
    rst = 1'b0;
    #1;
    check("async_rst_phase", 32'(phase), 32'h1);
    check("async_rst_pulses", {fetch_en, last_phase, retire, stall, exc_ack, illegal}, 0);
    check("async_rst_cnt", retired_cnt | stall_cnt, 0);
    repeat (2) @(negedge clk);
    #1;
    check("held_rst_idx", 32'(phase_idx), 0);
    check("held_rst_fetch", 32'(fetch_en), 0);
    rst = 1'b1;
    #1;
    check("release_fetch", 32'(fetch_en), 1);
    check("release_idx", 32'(phase_idx), 0);
    @(negedge clk);
    drive(0, 8'h01, 0, 0, 0);
    #1;
    check("after_release_idx", 32'(phase_idx), 1);
    check("after_release_cnt", retired_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
